// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: funct3 codes, FSM encoding and lane helpers for the load/store unit
package rv_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  function automatic logic bad_access(logic wr, logic [2:0] f3, logic [1:0] a);
    return !(wr ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      || (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
  function automatic logic [3:0] store_strb(logic [2:0] f3, logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] store_data(logic [2:0] f3, logic [31:0] d);
    return f3[1:0] == 2'b00 ? {4{d[7:0]}} : f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
  // halves shift by 16*addr[1], bytes by 8*addr; words are aligned so shift by 0
  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [31:0] s;
    logic sg;
    s = w >> (f3[0] ? {a[1], 4'b0000} : {a, 3'b000});
    sg = ~f3[2] & (f3[0] ? s[15] : s[7]);
    return f3[1] ? w : f3[0] ? {{16{sg}}, s[15:0]} : {{24{sg}}, s[7:0]};
  endfunction
endpackage

// File: rtl/rv_lsu_if.sv
// rv_lsu_if: word-wide data-memory request/response bus
interface rv_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_data;
  modport master(output req_valid, req_addr, req_wr, req_wdata, req_wstrb, input req_ready, resp_valid, resp_data);
  modport slave(input req_valid, req_addr, req_wr, req_wdata, req_wstrb, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/rv_lsu_lane.sv
// rv_lsu_lane: store strobe/data replication, access checking and load extraction
module rv_lsu_lane
  import rv_lsu_pkg::*;
(
  input  logic        wr,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_word,
  output logic        bad,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  assign bad   = bad_access(wr, st_funct3, st_addr);
  assign wstrb = wr ? store_strb(st_funct3, st_addr) : 4'b0000;
  assign wdata = store_data(st_funct3, st_data);
  assign rdata = load_ext(ld_funct3, ld_addr, ld_word);
endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit running the data-memory handshake for the decoder
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Mem_rd,
  input  logic            io_Mem_wr_valid,
  input  logic [2:0]      io_funct3,
  input  logic [XLEN-1:0] io_addr,
  input  logic [XLEN-1:0] io_wdata,
  output logic [XLEN-1:0] io_rdata,
  output logic            io_DataMem_rdy,
  output logic            io_fault,
  rv_lsu_if.master        io_dmem
);
  localparam int CW = $clog2(RESP_TIMEOUT + 2);
  state_t state;
  logic wr_q;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic [CW-1:0] cnt;
  logic bad, tmo;
  logic [3:0] st_strb;
  logic [31:0] st_data, ld_data;
  rv_lsu_lane u_lane (
    .wr(io_Mem_wr_valid), .st_funct3(io_funct3), .st_addr(io_addr[1:0]), .st_data(io_wdata),
    .ld_funct3(f3_q), .ld_addr(a_q), .ld_word(io_dmem.resp_data),
    .bad(bad), .wstrb(st_strb), .wdata(st_data), .rdata(ld_data)
  );
  assign tmo = (RESP_TIMEOUT != 0) && cnt == CW'(RESP_TIMEOUT - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wr_q <= 1'b0;
      f3_q <= 3'b000;
      a_q <= 2'b00;
      cnt <= '0;
      io_rdata <= '0;
      io_DataMem_rdy <= 1'b0;
      io_fault <= 1'b0;
      io_dmem.req_valid <= 1'b0;
      io_dmem.req_addr <= '0;
      io_dmem.req_wr <= 1'b0;
      io_dmem.req_wdata <= '0;
      io_dmem.req_wstrb <= 4'b0000;
    end else begin
      io_DataMem_rdy <= 1'b0;
      io_fault <= 1'b0;
      unique case (state)
        S_IDLE: if (io_Mem_rd | io_Mem_wr_valid) begin
          wr_q <= io_Mem_wr_valid;
          f3_q <= io_funct3;
          a_q <= io_addr[1:0];
          cnt <= '0;
          io_dmem.req_addr <= {io_addr[XLEN-1:2], 2'b00};
          io_dmem.req_wr <= io_Mem_wr_valid;
          io_dmem.req_wdata <= st_data;
          io_dmem.req_wstrb <= st_strb;
          if (bad) begin
            state <= S_DONE;
            io_DataMem_rdy <= 1'b1;
            io_fault <= 1'b1;
            io_rdata <= '0;
          end else begin
            state <= S_REQ;
            io_dmem.req_valid <= 1'b1;
          end
        end
        S_REQ: if (io_dmem.req_ready) begin
          io_dmem.req_valid <= 1'b0;
          cnt <= '0;
          state <= wr_q ? S_DONE : S_WAIT;
          io_DataMem_rdy <= wr_q;
          if (wr_q) io_rdata <= '0;
        end else if (tmo) begin
          io_dmem.req_valid <= 1'b0;
          state <= S_DONE;
          io_DataMem_rdy <= 1'b1;
          io_fault <= 1'b1;
          io_rdata <= '0;
        end else cnt <= cnt + 1'b1;
        S_WAIT: if (io_dmem.resp_valid) begin
          state <= S_DONE;
          io_DataMem_rdy <= 1'b1;
          io_rdata <= ld_data;
        end else if (tmo) begin
          state <= S_DONE;
          io_DataMem_rdy <= 1'b1;
          io_fault <= 1'b1;
          io_rdata <= '0;
        end else cnt <= cnt + 1'b1;
        S_DONE: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed vector table plus back-to-back and reset sequences for rv_lsu
module tb_rv_lsu;
  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          delay;
    bit          no_resp;
    bit          exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_lat;
    bit          exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [2:0] f3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic rdy, fault;
  int total = 0, bad = 0;
  vec_t vt[$];

  rv_lsu_if dmem ();
  rv_lsu #(.XLEN(32), .RESP_TIMEOUT(8)) dut (
    .clock(clk), .reset(rst), .io_Mem_rd(rd), .io_Mem_wr_valid(wr), .io_funct3(f3),
    .io_addr(addr), .io_wdata(wdata), .io_rdata(rdata), .io_DataMem_rdy(rdy),
    .io_fault(fault), .io_dmem(dmem)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // caller must be at a negedge; strobes go out immediately and drop at the rdy cycle
  task automatic run_op(input vec_t v);
    int lat = 0, waits = 0;
    bit seen = 0, acc = 0;
    rd = v.rd; wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      dmem.resp_valid = acc && !v.no_resp;
      dmem.resp_data = acc ? v.resp : 32'h0;
      acc = 0;
      if (rdy) begin
        lat = c;
        dmem.req_ready = 0;
      end else if (dmem.req_valid) begin
        seen = 1;
        chk("req_addr", dmem.req_addr, v.exp_addr);
        chk("req_wstrb", {28'h0, dmem.req_wstrb}, {28'h0, v.exp_strb});
        if (v.wr) chk("req_wdata", dmem.req_wdata, v.exp_wdata);
        dmem.req_ready = waits >= v.delay;
        acc = dmem.req_ready && !v.wr;
        waits++;
      end else dmem.req_ready = 0;
    end
    chk("latency", lat, v.exp_lat);
    chk("fault", {31'h0, fault}, {31'h0, v.exp_fault});
    chk("rdata", rdata, v.exp_rdata);
    chk("req_seen", {31'h0, seen}, {31'h0, v.exp_req});
    rd = 0; wr = 0;
  endtask

  initial begin
    bit quiet;
    dmem.req_ready = 0; dmem.resp_valid = 0; dmem.resp_data = '0;
    // {rd,wr,f3,addr,wdata,resp,delay,no_resp,exp_req,exp_addr,exp_strb,exp_wdata,exp_lat,exp_fault,exp_rdata}
    vt.push_back('{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'hDEADBEEF});
    vt.push_back('{1'b0, 1'b1, 3'd2, 32'h202, 32'h1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'hFFFFFF80});
    vt.push_back('{1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'h00000080});
    vt.push_back('{1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'h000080FF});
    vt.push_back('{1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'hFFFF80FF});
    vt.push_back('{1'b1, 1'b0, 3'd1, 32'h000, 32'h0, 32'h12347FFF, 0, 1'b0, 1'b1, 32'h000, 4'h0, 32'h0, 3, 1'b0, 32'h00007FFF});
    vt.push_back('{1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 32'h12347F56, 0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 3, 1'b0, 32'h0000007F});
    vt.push_back('{1'b1, 1'b0, 3'd1, 32'h201, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 4, 1'b0, 1'b1, 32'h200, 4'h2, 32'hABABABAB, 6, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b1, 3'd1, 32'h202, 32'h1234CDEF, 32'h0, 0, 1'b0, 1'b1, 32'h200, 4'hC, 32'hCDEFCDEF, 2, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0, 0, 1'b0, 1'b1, 32'h204, 4'hF, 32'hCAFEF00D, 2, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd6, 32'h100, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b1, 3'd4, 32'h200, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 3'd0, 32'h300, 32'h00000055, 32'h0, 0, 1'b0, 1'b1, 32'h300, 4'h1, 32'h55555555, 2, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 0, 1'b1, 1'b1, 32'h400, 4'h0, 32'h0, 10, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'h0, 100, 1'b0, 1'b1, 32'h404, 4'h0, 32'h0, 9, 1'b1, 32'h0});
    #12;
    chk("reset_rdy", {31'h0, rdy}, 32'h0);
    chk("reset_req_valid", {31'h0, dmem.req_valid}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 0;
    foreach (vt[i]) begin
      @(negedge clk);
      run_op(vt[i]);
    end
    // fault completion followed immediately by a held strobe: DONE->IDLE adds one cycle
    @(negedge clk);
    run_op('{1'b0, 1'b1, 3'd2, 32'h202, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h0});
    run_op('{1'b1, 1'b0, 3'd1, 32'h200, 32'h0, 32'h00008123, 0, 1'b0, 1'b1, 32'h200, 4'h0, 32'h0, 4, 1'b0, 32'hFFFF8123});
    // reset while waiting for a response, then a stale response must be ignored
    @(negedge clk);
    rd = 1; f3 = 3'd2; addr = 32'h500;
    @(negedge clk); dmem.req_ready = 1;
    @(negedge clk); dmem.req_ready = 0; rd = 0;
    #2 rst = 1;
    #1;
    chk("mid_reset_req_valid", {31'h0, dmem.req_valid}, 32'h0);
    chk("mid_reset_rdy", {31'h0, rdy}, 32'h0);
    chk("mid_reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 0;
    dmem.resp_valid = 1; dmem.resp_data = 32'h11111111;
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdy || fault || dmem.req_valid || rdata != 0) quiet = 0;
    end
    chk("stale_resp_ignored", {31'h0, quiet}, 32'h1);
    dmem.resp_valid = 0;
    run_op('{1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b1, 32'h500, 4'h0, 32'h0, 3, 1'b0, 32'h0BADF00D});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit sitting directly downstream of the control-path decoder.
- Consumes the decoder's memory-read and memory-write-valid strobes plus datapath address/store data.
- Runs the word-wide data-memory handshake and returns aligned, extended load data.
- Drives io_DataMem_rdy back to the decoder so the decoder can stall until the access completes.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- RESP_TIMEOUT, 255, cycles to wait for req_ready or resp_valid before raising io_fault. 0 disables the timeout.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- io_Mem_rd  in  1  load request from decoder; held until io_DataMem_rdy
- io_Mem_wr_valid  in  1  store request from decoder; held until io_DataMem_rdy
- io_funct3  in  3  IR[14:12] width/sign code
- io_addr  in  XLEN  effective byte address (ALU result)
- io_wdata  in  XLEN  rs2 store data
- io_rdata  out  XLEN  extended load result, valid while io_DataMem_rdy=1
- io_DataMem_rdy  out  1  one-cycle completion pulse to decoder
- io_fault  out  1  qualifies io_DataMem_rdy: misaligned, illegal funct3, or timeout
- io_dmem_req_valid  out  1  memory request valid
- io_dmem_req_ready  in  1  memory accepts request
- io_dmem_req_addr  out  XLEN  word address, {addr[31:2],2'b00}
- io_dmem_req_wr  out  1  1=write, 0=read
- io_dmem_req_wdata  out  XLEN  lane-replicated store data
- io_dmem_req_wstrb  out  4  byte enables; 0000 on reads
- io_dmem_resp_valid  in  1  read data valid
- io_dmem_resp_data  in  XLEN  read word

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0; captured registers 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE, request detected:
  - Capture addr, funct3, wdata, and op on (io_Mem_rd | io_Mem_wr_valid).
  - If both strobes are high, the store wins.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (011, 110, 111; loads also reject 110/111; stores accept only 000/001/010) -> DONE with fault. No memory request is issued.
  - Otherwise -> REQ.
- REQ: req_valid=1, with addr/wr/wdata/wstrb stable until req_ready.
  - On handshake: write -> DONE; read -> WAIT_RESP.
- WAIT_RESP: on resp_valid, extract lane, extend, register into io_rdata -> DONE.
- DONE: io_DataMem_rdy=1 for exactly one cycle, io_fault per captured status, then IDLE.
  - A strobe still high in the cycle after DONE is treated as a new instruction.
- Timeout: counter clears on entering REQ or WAIT_RESP. If it reaches RESP_TIMEOUT -> DONE with fault, and req_valid drops.
- resp_valid outside WAIT_RESP is ignored. This includes a stale response after reset mid-transaction.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{b}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{h}}.
  - SW: wstrb=1111.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign-/zero-extended.
  - LH/LHU: half at addr[1], sign-/zero-extended.
  - LW: full word.
- io_rdata holds its last value outside DONE. It is 0 after a faulted or store completion.
- Latency with zero-wait memory (ready=1, resp one cycle after acceptance):
  - Load: rdy 3 cycles after the strobe is sampled.
  - Store: rdy 2 cycles after the strobe is sampled.
  - Fault: rdy 1 cycle after the strobe is sampled.
- Reset during REQ/WAIT_RESP: immediate IDLE, req_valid=0, no rdy pulse.

Decomposition:
- Package rv_lsu_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU.
  - State encoding for IDLE/REQ/WAIT_RESP/DONE.
  - Store/load lane helper functions.
- Sub-module rv_lsu_lane: combinational store strobe/data generation and load extraction/extension, instantiated once.

Test Plan:
- LW addr 0x100, resp_data 0xDEADBEEF, ready=1 -> req_addr 0x100, wstrb 0000; rdy at cycle 3, rdata 0xDEADBEEF, fault 0.
- LB addr 0x103, resp 0x80FF_0000 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x000000AB, ready held 0 for 4 cycles -> req stable 4 cycles, wstrb 0010, wdata 0xABABABAB; rdy 1 cycle after ready.
- SW addr 0x202 -> no req_valid; rdy+fault at cycle 1. Then LH addr 0x200 next cycle proceeds normally.
- LW with resp_valid never asserted, RESP_TIMEOUT=8 -> rdy+fault 8 cycles after WAIT_RESP entry.
- Reset pulsed while in WAIT_RESP, then a stale resp_valid -> outputs 0, no rdy pulse; next load completes correctly.
